// File: rtl/rm_pkg.sv
// Shared types and default sizing for the instruction fetch unit.
package rm_pkg;

  localparam int RM_AW            = 9;
  localparam int RM_DW            = 16;
  localparam int RM_FETCH_TIMEOUT = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    LOAD = 2'd2,
    ERR  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/pc_register.sv
// Program counter: load has priority over increment, otherwise hold.
module pc_register
  import rm_pkg::*;
#(
  parameter int AW = RM_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          inc,
  input  logic [AW-1:0] load_val,
  output logic [AW-1:0] pc
);

  localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [AW-1:0] pc_q;
  logic [AW-1:0] pc_d;

  // Increment wraps naturally modulo 2^AW.
  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_val;
    end else if (inc) begin
      pc_d = pc_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch FSM: issues a memory read at pc, captures the word,
// pulses the IR load, and traps into a sticky error if memory never answers.
module instruction_fetch
  import rm_pkg::*;
#(
  parameter int AW      = RM_AW,
  parameter int DW      = RM_DW,
  parameter int TIMEOUT = RM_FETCH_TIMEOUT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          fetch_req,
  input  logic          pc_load,
  input  logic [AW-1:0] pc_target,
  output logic [AW-1:0] mem_addr,
  output logic          mem_read,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_rvalid,
  output logic [DW-1:0] ir_in,
  output logic          ir_load,
  output logic [AW-1:0] pc,
  output logic          fetch_done,
  output logic          fetch_err
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  fetch_state_t  state_q, state_d;
  logic [7:0]    wait_cnt_q, wait_cnt_d;
  logic [DW-1:0] ir_q, ir_d;
  logic          err_q, err_d;
  logic          pc_ld;
  logic          pc_inc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      ir_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      ir_q       <= ir_d;
      err_q      <= err_d;
    end
  end

  // A response on the last allowed WAIT cycle beats the timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (fetch_req) state_d = WAIT;
      WAIT: begin
        if (mem_rvalid) begin
          state_d = LOAD;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = ERR;
        end
      end
      LOAD:    state_d = IDLE;
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    ir_d       = ir_q;
    if (state_q == IDLE && fetch_req) begin
      wait_cnt_d = '0;
    end else if (state_q == WAIT && !mem_rvalid) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
    if (state_q == WAIT && mem_rvalid) begin
      ir_d = mem_rdata;
    end
    err_d = err_q | (state_d == ERR);
  end

  assign pc_ld  = (state_q == IDLE) && pc_load;
  assign pc_inc = (state_q == LOAD);

  pc_register #(.AW(AW)) u_pc (
    .clk      (clk),
    .reset    (reset),
    .load     (pc_ld),
    .inc      (pc_inc),
    .load_val (pc_target),
    .pc       (pc)
  );

  always_comb begin
    mem_read   = (state_q == WAIT);
    ir_load    = (state_q == LOAD);
    fetch_done = (state_q == LOAD);
  end

  assign mem_addr  = pc;
  assign ir_in     = ir_q;
  assign fetch_err = err_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed and randomized fetch sequences checked against a transaction-level
// model of pc / instruction word / error flag.
module tb_instruction_fetch;

  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_req = 1'b0;
  logic        pc_load = 1'b0;
  logic [8:0]  pc_target = '0;
  logic [8:0]  mem_addr;
  logic        mem_read;
  logic [15:0] mem_rdata = '0;
  logic        mem_rvalid = 1'b0;
  logic [15:0] ir_in;
  logic        ir_load;
  logic [8:0]  pc;
  logic        fetch_done;
  logic        fetch_err;

  int total = 0;
  int bad = 0;
  int model_pc = 0;
  int model_ir = 0;

  instruction_fetch dut (
    .clk        (clk),
    .reset      (reset),
    .fetch_req  (fetch_req),
    .pc_load    (pc_load),
    .pc_target  (pc_target),
    .mem_addr   (mem_addr),
    .mem_read   (mem_read),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .ir_in      (ir_in),
    .ir_load    (ir_load),
    .pc         (pc),
    .fetch_done (fetch_done),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    fetch_req = 1'b0;
    pc_load = 1'b0;
    mem_rvalid = 1'b0;
    tick();
    reset = 1'b0;
    model_pc = 0;
    model_ir = 0;
  endtask

  // Idle cycles with stray read-data strobes that must be ignored.
  task automatic idle_noise(input int n);
    for (int i = 0; i < n; i++) begin
      fetch_req = 1'b0;
      pc_load = 1'b0;
      mem_rvalid = 1'($urandom_range(0, 1));
      mem_rdata = 16'($urandom);
      tick();
      chk("idle_ir_held", 32'(ir_in), 32'(model_ir));
      chk("idle_pc_held", 32'(pc), 32'(model_pc));
      chk("idle_no_load", 32'(ir_load), 32'd0);
      chk("idle_no_read", 32'(mem_read), 32'd0);
    end
    mem_rvalid = 1'b0;
  endtask

  task automatic pc_only(input logic [8:0] tgt);
    pc_load = 1'b1;
    pc_target = tgt;
    tick();
    pc_load = 1'b0;
    model_pc = int'(tgt);
    chk("pcload_pc", 32'(pc), 32'(model_pc));
    chk("pcload_no_read", 32'(mem_read), 32'd0);
    $display("pc_load target=%03h pc=%03h", tgt, pc);
  endtask

  // One fetch transaction; lat = WAIT cycle on which memory responds.
  task automatic do_fetch(input int lat, input logic [15:0] data,
                          input logic ld, input logic [8:0] tgt);
    int addr;
    int n_wait;
    addr = ld ? int'(tgt) : model_pc;
    fetch_req = 1'b1;
    pc_load = ld;
    pc_target = tgt;
    mem_rvalid = 1'b0;
    tick();
    fetch_req = 1'b0;
    pc_load = 1'b0;
    n_wait = (lat <= TMO) ? lat : TMO;
    for (int c = 1; c <= n_wait; c++) begin
      chk("wait_read", 32'(mem_read), 32'd1);
      chk("wait_addr", 32'(mem_addr), 32'(addr));
      chk("wait_no_load", 32'(ir_load), 32'd0);
      chk("wait_ir_held", 32'(ir_in), 32'(model_ir));
      chk("wait_no_err", 32'(fetch_err), 32'd0);
      fetch_req = 1'($urandom_range(0, 1));
      pc_load = 1'($urandom_range(0, 1));
      pc_target = 9'($urandom);
      if (c == lat) begin
        mem_rvalid = 1'b1;
        mem_rdata = data;
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata = 16'($urandom);
      end
      tick();
    end
    if (lat <= TMO) begin
      chk("load_pulse", 32'(ir_load), 32'd1);
      chk("load_done", 32'(fetch_done), 32'd1);
      chk("load_ir", 32'(ir_in), 32'(data));
      chk("load_no_read", 32'(mem_read), 32'd0);
      chk("load_pc", 32'(pc), 32'(addr));
      fetch_req = 1'b1;
      pc_load = 1'b1;
      pc_target = 9'($urandom);
      mem_rvalid = 1'b1;
      mem_rdata = ~data;
      tick();
      fetch_req = 1'b0;
      pc_load = 1'b0;
      mem_rvalid = 1'b0;
      model_ir = int'(data);
      model_pc = (addr + 1) % 512;
      chk("after_no_load", 32'(ir_load), 32'd0);
      chk("after_no_done", 32'(fetch_done), 32'd0);
      chk("after_pc", 32'(pc), 32'(model_pc));
      chk("after_ir", 32'(ir_in), 32'(model_ir));
      $display("fetch addr=%03h lat=%0d data=%04h pc_next=%03h", addr, lat, data, pc);
    end else begin
      fetch_req = 1'b0;
      pc_load = 1'b0;
      mem_rvalid = 1'b0;
      model_pc = addr;
      chk("tmo_err", 32'(fetch_err), 32'd1);
      chk("tmo_no_read", 32'(mem_read), 32'd0);
      chk("tmo_no_load", 32'(ir_load), 32'd0);
      chk("tmo_pc", 32'(pc), 32'(model_pc));
      $display("fetch addr=%03h no response -> error flag=%0d", addr, fetch_err);
    end
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_ir", 32'(ir_in), 32'd0);
    chk("rst_read", 32'(mem_read), 32'd0);
    chk("rst_load", 32'(ir_load), 32'd0);
    chk("rst_done", 32'(fetch_done), 32'd0);
    chk("rst_err", 32'(fetch_err), 32'd0);

    do_fetch(1, 16'hAAAA, 1'b0, 9'h000);
    do_fetch(5, 16'h5555, 1'b0, 9'h000);
    do_fetch(2, 16'hC3C3, 1'b1, 9'h1FF);
    idle_noise(3);
    do_fetch(TMO, 16'h0F0F, 1'b0, 9'h000);

    for (int t = 0; t < 25; t++) begin
      if ($urandom_range(0, 4) == 0) pc_only(9'($urandom));
      do_fetch(int'($urandom_range(1, 7)), 16'($urandom),
               1'($urandom_range(0, 1)), 9'($urandom));
      idle_noise(int'($urandom_range(0, 2)));
    end

    // Reset during WAIT with a same-cycle response: fetch must be abandoned.
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    chk("abort_in_wait", 32'(mem_read), 32'd1);
    reset = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata = 16'h1234;
    tick();
    reset = 1'b0;
    model_pc = 0;
    model_ir = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_load", 32'(ir_load), 32'd0);
      chk("abort_ir", 32'(ir_in), 32'd0);
      chk("abort_pc", 32'(pc), 32'd0);
      chk("abort_no_read", 32'(mem_read), 32'd0);
    end
    mem_rvalid = 1'b0;
    $display("reset during WAIT, stray 1234 in IDLE: ir_in=%04h pc=%03h", ir_in, pc);

    // Reset during LOAD: no pulse afterwards, pc not incremented.
    pc_only(9'h0A5);
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = 16'hBEEF;
    tick();
    mem_rvalid = 1'b0;
    chk("abort_load_pulse", 32'(ir_load), 32'd1);
    do_reset();
    chk("abort_load_gone", 32'(ir_load), 32'd0);
    chk("abort_load_pc", 32'(pc), 32'd0);
    chk("abort_load_ir", 32'(ir_in), 32'd0);
    $display("reset during LOAD: ir_load=%0d pc=%03h", ir_load, pc);

    // Timeout, sticky error, and recovery by reset.
    do_fetch(2, 16'h7E7E, 1'b0, 9'h000);
    do_fetch(TMO + 1, 16'h0000, 1'b1, 9'h123);
    for (int i = 0; i < 4; i++) begin
      fetch_req = 1'b1;
      pc_load = 1'b1;
      pc_target = 9'($urandom);
      mem_rvalid = 1'b1;
      mem_rdata = 16'($urandom);
      tick();
      chk("err_sticky", 32'(fetch_err), 32'd1);
      chk("err_no_read", 32'(mem_read), 32'd0);
      chk("err_no_load", 32'(ir_load), 32'd0);
      chk("err_pc_held", 32'(pc), 32'(model_pc));
      chk("err_ir_held", 32'(ir_in), 32'(model_ir));
    end
    do_reset();
    chk("err_cleared", 32'(fetch_err), 32'd0);
    chk("err_rst_pc", 32'(pc), 32'd0);
    do_fetch(3, 16'h4321, 1'b0, 9'h000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
